vga_sync_receiver: RTL and testbench
====================================

VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

Interface
REQ-001 SHALL have parameters H_VISIBLE=640, H_FRONT=16, H_SYNC=96, H_BACK=48, V_VISIBLE=480, V_FRONT=10, V_SYNC=2, V_BACK=33.
REQ-002 SHALL derive H_TOTAL=sum of H params (800), V_TOTAL=sum of V params (525), H_ACT=H_SYNC+H_BACK (144), V_ACT=V_SYNC+V_BACK (35).
REQ-003 Ports, clock and reset first:
  clk  in  1  single clock, one pixel per rising edge
  reset  in  1  asynchronous, active-low reset
  hSync  in  1  horizontal sync, active-low, synchronous to clk
  vSync  in  1  vertical sync, active-low, synchronous to clk
  R, G, B  in  1 each  pixel colour
  dataEnable  out  1  registered active-pixel strobe
  xPosition  out  10  active column of the current pixel
  yPosition  out  10  active row of the current pixel
  rOut, gOut, bOut  out  1 each  registered pixel colour
  locked  out  1  timing lock indicator
  syncError  out  1  sticky error flag
  errorCount  out  8  saturating error counter
  frameCount  out  16  locked-frame counter, wraps

Function
REQ-004 SHALL keep 1-cycle delayed copies hS_d and vS_d; falling edge = current input 0 and delayed copy 1.
REQ-005 hCount (10 b) SHALL load 0 on an hSync falling edge, else increment, saturating at 1023.
REQ-006 lineCount (10 b) SHALL load 0 on a vSync falling edge (priority over hSync), else increment on an hSync falling edge, saturating at 1023.
REQ-007 Active window: next-hCount in [H_ACT, H_ACT+H_VISIBLE-1] and lineCount in [V_ACT, V_ACT+V_VISIBLE-1].
REQ-008 On the edge that samples a pixel inside the active window while LOCKED, outputs SHALL update in the same edge: dataEnable=1, xPosition=next-hCount-H_ACT, yPosition=lineCount-V_ACT, rOut/gOut/bOut=R/G/B. This gives 1-cycle latency from input to output.
REQ-009 Outside the window, or when not LOCKED, dataEnable=0, rOut/gOut/bOut=0, and xPosition/yPosition hold their values.
REQ-010 FSM states: SEARCH, ACQUIRE, LOCKED; locked=1 only in LOCKED.
REQ-011 SEARCH -> ACQUIRE on a vSync falling edge.
REQ-012 Line error: an hSync falling edge when hCount != H_TOTAL-1, excluding the first hSync edge after entering ACQUIRE.
REQ-013 Frame error: a vSync falling edge when lineCount != V_TOTAL-1.
REQ-014 Timeout error: hCount reaches 1023.
REQ-015 ACQUIRE -> LOCKED on the next vSync falling edge if no error occurred in ACQUIRE; any error returns to SEARCH.
REQ-016 LOCKED -> SEARCH on any error in the same edge; dataEnable=0 from that edge.
REQ-017 Errors in ACQUIRE or LOCKED SHALL set syncError (sticky) and increment errorCount, saturating at 255. Errors in SEARCH are ignored.
REQ-018 frameCount SHALL increment on each error-free vSync falling edge in LOCKED, including the ACQUIRE->LOCKED edge, and wrap 65535->0.
REQ-019 Simultaneous line error and frame error SHALL count as one error.

Reset
REQ-020 reset=0 SHALL immediately force: state=SEARCH; hCount=0, lineCount=0; hS_d=1, vS_d=1; all outputs 0.
REQ-021 Reset asserted mid-frame SHALL abort lock; after release, the block requires one full SEARCH->ACQUIRE->LOCKED sequence before asserting dataEnable.

Verification
REQ-022 Two clean 800x525 frames from reset: locked=1 at the second vSync fall, frameCount=1; dataEnable first rises with x=0, y=0 and matching RGB 1 clk after pixel input; 307200 dataEnable cycles per frame.
REQ-023 Active pixel at column 639, row 479: xPosition=639, yPosition=479; the next cycle dataEnable=0.
REQ-024 One 799-clk line while LOCKED: locked=0 at that hSync edge, syncError=1, errorCount=1; relock after two clean frames.
REQ-025 hSync held high for 1100 clks while LOCKED: timeout at hCount=1023, locked=0, errorCount increments exactly once.
REQ-026 Inject 300 errors: errorCount=255 and holds; reset low mid-line forces all outputs to 0 asynchronously.

Source files
------------

// File: rtl/vga_sync_receiver.sv
//------------------------------------------------------------------------------
// Module      : vga_sync_receiver
// Description : Recovers VGA timing from hSync/vSync and emits registered
//               active-pixel strobe, coordinates and colour once locked.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vga_sync_receiver #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hSync,
  input  logic        vSync,
  input  logic        R,
  input  logic        G,
  input  logic        B,
  output logic        dataEnable,
  output logic [9:0]  xPosition,
  output logic [9:0]  yPosition,
  output logic        rOut,
  output logic        gOut,
  output logic        bOut,
  output logic        locked,
  output logic        syncError,
  output logic [7:0]  errorCount,
  output logic [15:0] frameCount
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_ACT   = H_SYNC + H_BACK;
  localparam int V_ACT   = V_SYNC + V_BACK;

  localparam logic [9:0] c_countMax   = 10'd1023;
  localparam logic [9:0] c_hLast      = 10'(H_TOTAL - 1);
  localparam logic [9:0] c_vLast      = 10'(V_TOTAL - 1);
  localparam logic [9:0] c_hFirstVis  = 10'(H_ACT);
  localparam logic [9:0] c_hLastVis   = 10'(H_ACT + H_VISIBLE - 1);
  localparam logic [9:0] c_vFirstVis  = 10'(V_ACT);
  localparam logic [9:0] c_vLastVis   = 10'(V_ACT + V_VISIBLE - 1);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_nextState;

  logic       hS_d;
  logic       vS_d;
  logic [9:0] hCount;
  logic [9:0] lineCount;
  logic       r_skipFirstH;

  logic       w_hFall;
  logic       w_vFall;
  logic [9:0] w_hCountNext;
  logic [9:0] w_lineCountNext;
  logic       w_lineErr;
  logic       w_frameErr;
  logic       w_timeout;
  logic       w_err;
  logic       w_active;
  logic       w_pixelOn;
  logic       w_frameInc;

  // Edge detection and free-running position counters
  always_comb begin
    w_hFall = ~hSync & hS_d;
    w_vFall = ~vSync & vS_d;

    w_hCountNext = hCount;
    if (w_hFall)
      w_hCountNext = '0;
    else if (hCount != c_countMax)
      w_hCountNext = hCount + 10'd1;

    w_lineCountNext = lineCount;
    if (w_vFall)
      w_lineCountNext = '0;
    else if (w_hFall && (lineCount != c_countMax))
      w_lineCountNext = lineCount + 10'd1;
  end

  // Timing checks; line and frame errors on the same edge collapse into one
  always_comb begin
    w_lineErr  = w_hFall && (hCount != c_hLast)
                 && !((r_state == ACQUIRE) && r_skipFirstH);
    w_frameErr = w_vFall && (lineCount != c_vLast);
    w_timeout  = (w_hCountNext == c_countMax) && (hCount != c_countMax);
    w_err      = (r_state != SEARCH) && (w_lineErr || w_frameErr || w_timeout);

    w_active   = (w_hCountNext >= c_hFirstVis) && (w_hCountNext <= c_hLastVis)
              && (lineCount >= c_vFirstVis) && (lineCount <= c_vLastVis);
    w_pixelOn  = (r_state == LOCKED) && !w_err && w_active;
    w_frameInc = (r_state != SEARCH) && w_vFall && !w_err;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      SEARCH: begin
        if (w_vFall)
          w_nextState = ACQUIRE;
      end
      ACQUIRE: begin
        if (w_err)
          w_nextState = SEARCH;
        else if (w_vFall)
          w_nextState = LOCKED;
      end
      LOCKED: begin
        if (w_err)
          w_nextState = SEARCH;
      end
      default: w_nextState = SEARCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= SEARCH;
    else
      r_state <= w_nextState;
  end

  assign locked = (r_state == LOCKED);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hS_d         <= 1'b1;
      vS_d         <= 1'b1;
      hCount       <= '0;
      lineCount    <= '0;
      r_skipFirstH <= 1'b0;
      dataEnable   <= 1'b0;
      xPosition    <= '0;
      yPosition    <= '0;
      rOut         <= 1'b0;
      gOut         <= 1'b0;
      bOut         <= 1'b0;
      syncError    <= 1'b0;
      errorCount   <= '0;
      frameCount   <= '0;
    end else begin
      hS_d      <= hSync;
      vS_d      <= vSync;
      hCount    <= w_hCountNext;
      lineCount <= w_lineCountNext;

      // The first line seen after acquiring vSync may be partial, so skip it
      if ((r_state == SEARCH) && (w_nextState == ACQUIRE))
        r_skipFirstH <= 1'b1;
      else if (w_hFall)
        r_skipFirstH <= 1'b0;

      if (w_pixelOn) begin
        dataEnable <= 1'b1;
        xPosition  <= w_hCountNext - c_hFirstVis;
        yPosition  <= lineCount - c_vFirstVis;
        rOut       <= R;
        gOut       <= G;
        bOut       <= B;
      end else begin
        dataEnable <= 1'b0;
        rOut       <= 1'b0;
        gOut       <= 1'b0;
        bOut       <= 1'b0;
      end

      if (w_err) begin
        syncError <= 1'b1;
        if (errorCount != 8'hFF)
          errorCount <= errorCount + 8'd1;
      end

      if (w_frameInc)
        frameCount <= frameCount + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_receiver.sv
//------------------------------------------------------------------------------
// Module      : tb_vga_sync_receiver
// Description : Directed self-checking bench using a reduced 16x9 raster.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vga_sync_receiver;

  localparam int HV = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 3;
  localparam int VV = 4;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int HT = HV + HF + HS + HB;  // 16
  localparam int VT = VV + VF + VS + VB;  // 9
  localparam int HA = HS + HB;            // 6
  localparam int VA = VS + VB;            // 4

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        hSync = 1'b1;
  logic        vSync = 1'b1;
  logic        R = 1'b0;
  logic        G = 1'b0;
  logic        B = 1'b0;
  logic        dataEnable;
  logic [9:0]  xPosition;
  logic [9:0]  yPosition;
  logic        rOut;
  logic        gOut;
  logic        bOut;
  logic        locked;
  logic        syncError;
  logic [7:0]  errorCount;
  logic [15:0] frameCount;

  int nChecks = 0;
  int nErrors = 0;
  int dutDeCount = 0;
  int lastX = 0;
  int lastY = 0;

  vga_sync_receiver #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .reset(reset), .hSync(hSync), .vSync(vSync),
    .R(R), .G(G), .B(B),
    .dataEnable(dataEnable), .xPosition(xPosition), .yPosition(yPosition),
    .rOut(rOut), .gOut(gOut), .bOut(bOut),
    .locked(locked), .syncError(syncError),
    .errorCount(errorCount), .frameCount(frameCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] pixColour(input int col, input int row);
    logic [31:0] c;
    logic [31:0] r;
    c = col;
    r = row;
    return {c[0], r[0], c[1] ^ r[1]};
  endfunction

  // Drives columns startCol..len-1 of one line and checks every output pixel
  task automatic runLine(input int row, input int startCol, input int len,
                         input bit expLocked, input int lockChk);
    logic expDe;
    for (int c = startCol; c < len; c++) begin
      @(negedge clk);
      hSync = (c < HS) ? 1'b0 : 1'b1;
      vSync = (row < VS) ? 1'b0 : 1'b1;
      {R, G, B} = pixColour(c, row);
      @(posedge clk);
      #1;
      if (c == 0 && lockChk >= 0)
        check("locked_at_line_start", {31'd0, locked}, lockChk);
      expDe = expLocked && (c >= HA) && (c < HA + HV) && (row >= VA) && (row < VA + VV);
      if (dataEnable === 1'b1)
        dutDeCount++;
      check("dataEnable", {31'd0, dataEnable}, {31'd0, expDe});
      if (expDe) begin
        lastX = c - HA;
        lastY = row - VA;
        check("rgb", {29'd0, rOut, gOut, bOut}, {29'd0, pixColour(c, row)});
      end else begin
        check("rgb_idle", {29'd0, rOut, gOut, bOut}, 32'd0);
      end
      check("xPosition", {22'd0, xPosition}, lastX);
      check("yPosition", {22'd0, yPosition}, lastY);
    end
  endtask

  task automatic runFrame(input bit expLocked, input int lockChk);
    dutDeCount = 0;
    for (int r = 0; r < VT; r++)
      runLine(r, 0, HT, expLocked, (r == 0) ? lockChk : -1);
  endtask

  task automatic idleCycle(input logic h, input logic v);
    @(negedge clk);
    hSync = h;
    vSync = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_dataEnable", {31'd0, dataEnable}, 32'd0);
    check("rst_xPosition", {22'd0, xPosition}, 32'd0);
    check("rst_yPosition", {22'd0, yPosition}, 32'd0);
    check("rst_syncError", {31'd0, syncError}, 32'd0);
    check("rst_errorCount", {24'd0, errorCount}, 32'd0);
    check("rst_frameCount", {16'd0, frameCount}, 32'd0);
    reset = 1'b1;

    // Frame 1 acquires, frame 2 locks at its first vSync fall
    runFrame(1'b0, 0);
    check("f1_frameCount", {16'd0, frameCount}, 32'd0);
    runFrame(1'b1, 1);
    check("f2_frameCount", {16'd0, frameCount}, 32'd1);
    check("f2_deCount", dutDeCount, HV * VV);
    check("f2_lastX", {22'd0, xPosition}, HV - 1);
    check("f2_lastY", {22'd0, yPosition}, VV - 1);
    runFrame(1'b1, 1);
    check("f3_frameCount", {16'd0, frameCount}, 32'd2);
    check("f3_deCount", dutDeCount, HV * VV);

    // Frame 4: row 5 is one clock short, caught at row 6 hSync fall
    for (int r = 0; r < VT; r++)
      runLine(r, 0, (r == 5) ? HT - 1 : HT, r < 6, (r == 0) ? 1 : ((r == 6) ? 0 : -1));
    check("short_syncError", {31'd0, syncError}, 32'd1);
    check("short_errorCount", {24'd0, errorCount}, 32'd1);
    check("short_frameCount", {16'd0, frameCount}, 32'd3);

    // Relock: frame 5 acquires, frame 6 locked
    runFrame(1'b0, 0);
    runFrame(1'b1, 1);
    check("relock_frameCount", {16'd0, frameCount}, 32'd4);
    check("relock_deCount", dutDeCount, HV * VV);
    check("relock_errorCount", {24'd0, errorCount}, 32'd1);

    // hSync stuck high: hCount climbs from 15 and reaches 1023 at step 1008
    for (int k = 1; k <= 1100; k++) begin
      idleCycle(1'b1, 1'b1);
      if (k == 1007) begin
        check("timeout_pre_locked", {31'd0, locked}, 32'd1);
        check("timeout_pre_errorCount", {24'd0, errorCount}, 32'd1);
      end
      if (k == 1008) begin
        check("timeout_locked", {31'd0, locked}, 32'd0);
        check("timeout_errorCount", {24'd0, errorCount}, 32'd2);
      end
    end
    check("timeout_once_errorCount", {24'd0, errorCount}, 32'd2);

    // Each 4-cycle burst enters ACQUIRE, then a premature vSync fall errors out
    for (int n = 1; n <= 300; n++) begin
      idleCycle(1'b0, 1'b0);
      idleCycle(1'b1, 1'b1);
      idleCycle(1'b1, 1'b0);
      idleCycle(1'b1, 1'b1);
      if (n == 252)
        check("inject_errorCount_254", {24'd0, errorCount}, 32'd254);
      if (n == 253)
        check("inject_errorCount_255", {24'd0, errorCount}, 32'd255);
    end
    check("inject_errorCount_sat", {24'd0, errorCount}, 32'd255);
    check("inject_locked", {31'd0, locked}, 32'd0);

    // Acquire and lock again, then abort mid-line with reset
    runFrame(1'b0, 0);
    for (int r = 0; r < VA; r++)
      runLine(r, 0, HT, 1'b1, (r == 0) ? 1 : -1);
    runLine(VA, 0, 10, 1'b1, -1);
    check("pre_rst_frameCount", {16'd0, frameCount}, 32'd5);
    check("pre_rst_xPosition", {22'd0, xPosition}, 32'd3);
    #1;
    reset = 1'b0;
    #1;
    check("async_rst_dataEnable", {31'd0, dataEnable}, 32'd0);
    check("async_rst_locked", {31'd0, locked}, 32'd0);
    check("async_rst_position", {12'd0, xPosition, yPosition}, 32'd0);
    check("async_rst_rgb", {29'd0, rOut, gOut, bOut}, 32'd0);
    check("async_rst_syncError", {31'd0, syncError}, 32'd0);
    check("async_rst_errorCount", {24'd0, errorCount}, 32'd0);
    check("async_rst_frameCount", {16'd0, frameCount}, 32'd0);
    lastX = 0;
    lastY = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Remaining lines of the aborted frame stay dark; then a full relock
    runLine(VA, 10, HT, 1'b0, -1);
    for (int r = VA + 1; r < VT; r++)
      runLine(r, 0, HT, 1'b0, -1);
    runFrame(1'b0, 0);
    runFrame(1'b1, 1);
    check("post_rst_frameCount", {16'd0, frameCount}, 32'd1);
    check("post_rst_deCount", dutDeCount, HV * VV);
    check("post_rst_errorCount", {24'd0, errorCount}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

`default_nettype wire
